// File: rtl/spi_pkg.sv
// Shared definitions for the SPI SD-card controller byte path.
package spi_pkg;

  localparam int unsigned DivWDefault = 8;
  localparam logic        SpiIdleMosi = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_clkdiv.sv
// Loadable down-counter with zero flag; paces each sck phase.
module spi_clkdiv #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      // Saturate at zero so a stray decrement can never wrap and stretch a phase.
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter between the TX byte FIFO and the RX byte FIFO.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             rx_discard,
  input  logic [7:0]       tx_q,
  input  logic             tx_empty,
  output logic             tx_rdreq,
  output logic [7:0]       rx_data,
  output logic             rx_wrreq,
  input  logic             rx_full,
  output logic             sck,
  output logic             mosi,
  input  logic             miso,
  output logic             busy
);

  spi_state_e       state_q, state_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic [7:0]       shift_tx_q, shift_tx_d;
  logic [7:0]       shift_rx_q, shift_rx_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       bit_nxt;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic             discard_q, discard_d;

  logic             start;
  logic             cnt_load;
  logic [DIV_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  spi_clkdiv #(
    .W (DIV_W)
  ) u_clkdiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Sole RX writer: room checked at start stays available until DONE.
  assign start   = (state_q == StIdle) && enable && !tx_empty && (rx_discard || !rx_full);
  assign bit_nxt = bit_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    shift_tx_d   = shift_tx_q;
    shift_rx_d   = shift_rx_q;
    rx_data_d    = rx_data_q;
    bit_d        = bit_q;
    div_l_d      = div_l_q;
    discard_d    = discard_q;
    cnt_load     = 1'b0;
    cnt_load_val = div_l_q;
    cnt_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_tx_d   = tx_q;
          mosi_d       = tx_q[7];
          div_l_d      = div;
          cnt_load     = 1'b1;
          cnt_load_val = div;
          discard_d    = rx_discard;
          bit_d        = 3'd0;
          state_d      = StLo;
        end
      end
      StLo: begin
        if (cnt_zero) begin
          sck_d      = 1'b1;
          shift_rx_d = {shift_rx_q[6:0], miso};
          cnt_load   = 1'b1;
          state_d    = StHi;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StHi: begin
        if (cnt_zero) begin
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            // All eight samples are already in the shifter at this point.
            rx_data_d = shift_rx_q;
            state_d   = StDone;
          end else begin
            bit_d    = bit_nxt;
            mosi_d   = shift_tx_q[3'd7 - bit_nxt];
            cnt_load = 1'b1;
            state_d  = StLo;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StDone: begin
        mosi_d  = SpiIdleMosi;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sck_q      <= 1'b0;
      mosi_q     <= SpiIdleMosi;
      shift_tx_q <= 8'h00;
      shift_rx_q <= 8'h00;
      rx_data_q  <= 8'h00;
      bit_q      <= 3'd0;
      div_l_q    <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      rx_data_q  <= rx_data_d;
      bit_q      <= bit_d;
      div_l_q    <= div_l_d;
      discard_q  <= discard_d;
    end
  end

  assign tx_rdreq = start;
  assign rx_wrreq = (state_q == StDone) && !discard_q;
  assign busy     = (state_q != StIdle);
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;

endmodule

// File: doc/spi_byte_engine.md
Name: spi_byte_engine

Overview:
- SPI mode-0 byte shifter for the SPI SD card controller; sits between the TX byte FIFO (upstream) and the RX byte FIFO (downstream).
- Pops one byte from TX FIFO, shifts it MSB-first on mosi while sampling miso, pushes the received byte into RX FIFO.
- Programmable sck rate; back-to-back bytes while TX FIFO non-empty.

Parameters:
- DIV_W, 8, width of clock-divider value div.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active low.
- enable  in  1  permits starting new bytes; sampled only in IDLE.
- div  in  DIV_W  sck half-period minus one, in clk cycles; latched at byte start.
- rx_discard  in  1  1 = do not push received byte; latched at byte start.
- tx_q  in  8  TX FIFO head byte (valid same cycle when tx_empty=0).
- tx_empty  in  1  TX FIFO empty.
- tx_rdreq  out  1  TX FIFO pop strobe.
- rx_data  out  8  byte for RX FIFO.
- rx_wrreq  out  1  RX FIFO push strobe.
- rx_full  in  1  RX FIFO full.
- sck  out  1  SPI clock, idle low.
- mosi  out  1  SPI data out, idles high.
- miso  in  1  SPI data in.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, sck=0, mosi=1, rx_data=0, bit counter=0, div counter=0. tx_rdreq=0, rx_wrreq=0 and busy=0 follow from IDLE. Reset mid-byte aborts immediately: no push, no further pop.
- States: IDLE, LO, HI, DONE.
- start = IDLE && enable && !tx_empty && (rx_discard || !rx_full).
- tx_rdreq is combinational and equals start.
- rx_wrreq is combinational and equals (state==DONE && !discard_l).
- IDLE, start cycle:
  - shift_tx<=tx_q, mosi<=tx_q[7].
  - div_l<=div, cnt<=div, discard_l<=rx_discard, bit<=0.
  - go to LO.
- LO: cnt decrements each cycle. At cnt==0: sck<=1, shift_rx<={shift_rx[6:0],miso}, cnt<=div_l, go to HI.
- HI: cnt decrements each cycle. At cnt==0: sck<=0, then:
  - if bit==7: rx_data<={shift_rx[6:0]... final assembled byte}, go to DONE.
  - else: bit<=bit+1, mosi<=next tx bit (MSB-first), cnt<=div_l, go to LO.
- DONE: one cycle; mosi<=1; go to IDLE.
- Timing:
  - Each sck phase lasts div_l+1 clk cycles.
  - Byte occupies 1 + 16*(div_l+1) + 1 cycles from start cycle to IDLE.
  - Next start is possible in the first IDLE cycle.
  - div=0 gives sck = clk/2.
- mosi changes only on sck falling edge or at byte start, so it is stable across every rising edge. miso is sampled at the rising edge.
- RX flow control:
  - A byte starts only if the RX FIFO has room (or discard); since this block is the sole RX writer, room persists until DONE.
  - rx_wrreq is never asserted while rx_full=1, except if sclr of the RX FIFO races; a push into a full FIFO is dropped by that FIFO.
- enable low, or div / rx_discard changes mid-byte: the current byte completes with its latched values.
- tx_empty rising mid-byte: no effect. Only one pop per byte, always in the start cycle.

Decomposition:
- Shared package (spi_pkg): state encoding constants (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3), DIV_W default, SPI_IDLE_MOSI=1'b1.
- Optional sub-module spi_clkdiv: loadable down-counter with zero flag, reused by the future slow-init clock path. The FSM and shifters stay in this module.

Test Plan:
- Single byte, div=0, tx_q=8'hA5, miso driven from pattern 8'h3C on falling edges:
  - tx_rdreq for exactly 1 cycle.
  - mosi bits 1,0,1,0,0,1,0,1 at sck rises.
  - rx_wrreq 1 cycle with rx_data=8'h3C, 18 cycles after start.
- Back-to-back, div=3, TX FIFO holding 8'h00, 8'hFF, 8'h81: three pops; start cycles 66 cycles apart; sck high/low phases each 4 cycles; rx_data matches miso loopback (miso=mosi).
- rx_full=1 with tx non-empty, rx_discard=0: no tx_rdreq, busy=0. Release rx_full -> start the next cycle. Repeat with rx_discard=1: byte runs, rx_wrreq never asserted.
- Mid-byte rst_n=0 after 3 bits: next cycle sck=0, mosi=1, busy=0, no rx_wrreq. After release, the next FIFO byte starts normally.
- div changed 7->0 and enable dropped mid-byte: byte completes at div=7 timing; no new start while enable=0.
- div=255 boundary: each phase lasts 256 cycles; counter wrap does not extend any phase.
